// File: rtl/prf_read_req_arbiter_pkg.sv
// Purpose: shared PRF and read-request sizing constants for the PRF read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prf_read_req_arbiter_pkg;

    localparam int LOG_PR_COUNT         = 7;
    localparam int PRF_BANK_COUNT       = 4;
    localparam int LOG_PRF_BANK_COUNT   = 2;
    localparam int PRF_RD_REQ_COUNT     = 4;
    localparam int LOG_PRF_RD_REQ_COUNT = 2;

    typedef logic [LOG_PR_COUNT-1:0]         pr_idx_t;
    typedef logic [LOG_PRF_RD_REQ_COUNT-1:0] rd_req_id_t;

endpackage

// File: rtl/prf_rr_pick.sv
// Purpose: round-robin picker; first set candidate at index >= rr_ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; a grant is only a selection, the caller decides what to do with it.
//
// Ports:
//   cand_vld  in   N   candidate vector
//   rr_ptr    in   W   highest-priority index this cycle (must be < N)
//   gnt_vld   out  1   some candidate was picked
//   gnt_idx   out  W   picked index (0 when gnt_vld=0)
module prf_rr_pick
    import prf_read_req_arbiter_pkg::*;
#(
    parameter int N = PRF_RD_REQ_COUNT,
    parameter int W = LOG_PRF_RD_REQ_COUNT
) (
    input  logic [N-1:0] cand_vld,
    input  logic [W-1:0] rr_ptr,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest candidate after
    // rr_ptr is the last one written and therefore wins. The wrap is an
    // explicit compare-and-subtract so N need not be a power of two.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int i = 0; i < N; i++) begin
                if (idx == i && cand_vld[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prf_read_req_arbiter.sv
// Purpose: holds one pending PRF read per requester, grants at most one read per bank per cycle, round-robin per bank.
// Latency: request accepted at edge E drives rd_valid/rd_grant after edge E+1 at the earliest, E+REQ_COUNT worst case.
// Backpressure: req_ready low while the requester's slot is occupied; a req_valid without ready is dropped, not queued.
//
// Ports:
//   CLK, RST               clock; synchronous active-high reset (priority over everything)
//   req_valid_by_req       in   REQ_COUNT            new read request
//   req_PR_by_req          in   REQ_COUNT x PR_W     PR to read, low LOG_BANK bits select the bank
//   req_ready_by_req       out  REQ_COUNT            slot can accept
//   kill_by_req            in   REQ_COUNT            squash the pending request (beats a grant)
//   rd_valid_by_bank       out  BANK_COUNT           registered PRF read enable
//   rd_upper_PR_by_bank    out  BANK_COUNT x (PR_W-LOG_BANK)  registered in-bank PR index
//   rd_req_id_by_bank      out  BANK_COUNT x LOG_REQ registered granted requester
//   rd_grant_by_req        out  REQ_COUNT            registered one-cycle grant pulse
//
// Build option PRF_ARB_BYPASS_READY_EN: when defined, a requester being granted
// (and not killed) is ready in the same cycle, so it can issue back-to-back reads.
module prf_read_req_arbiter
    import prf_read_req_arbiter_pkg::*;
#(
    parameter int REQ_COUNT  = PRF_RD_REQ_COUNT,
    parameter int BANK_COUNT = PRF_BANK_COUNT,
    parameter int LOG_BANK   = LOG_PRF_BANK_COUNT,
    parameter int PR_W       = LOG_PR_COUNT,
    parameter int LOG_REQ    = LOG_PRF_RD_REQ_COUNT
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic [REQ_COUNT-1:0]                          req_valid_by_req,
    input  logic [REQ_COUNT-1:0][PR_W-1:0]                req_PR_by_req,
    output logic [REQ_COUNT-1:0]                          req_ready_by_req,
    input  logic [REQ_COUNT-1:0]                          kill_by_req,
    output logic [BANK_COUNT-1:0]                         rd_valid_by_bank,
    output logic [BANK_COUNT-1:0][PR_W-LOG_BANK-1:0]      rd_upper_PR_by_bank,
    output logic [BANK_COUNT-1:0][LOG_REQ-1:0]            rd_req_id_by_bank,
    output logic [REQ_COUNT-1:0]                          rd_grant_by_req
);

    // Pending request slots
    logic [REQ_COUNT-1:0]                     pend_valid_q, pend_valid_d;
    logic [REQ_COUNT-1:0][PR_W-1:0]           pend_pr_q, pend_pr_d;

    // Per-bank round-robin pointers
    logic [BANK_COUNT-1:0][LOG_REQ-1:0]       rr_ptr_q, rr_ptr_d;

    // Output registers
    logic [BANK_COUNT-1:0]                    rd_valid_q, rd_valid_d;
    logic [BANK_COUNT-1:0][PR_W-LOG_BANK-1:0] rd_upper_pr_q, rd_upper_pr_d;
    logic [BANK_COUNT-1:0][LOG_REQ-1:0]       rd_req_id_q, rd_req_id_d;
    logic [REQ_COUNT-1:0]                     rd_grant_q, rd_grant_d;

    // Combinational arbitration
    logic [BANK_COUNT-1:0][REQ_COUNT-1:0]     cand;
    logic [BANK_COUNT-1:0]                    gnt_vld;
    logic [BANK_COUNT-1:0][LOG_REQ-1:0]       gnt_idx;
    logic [REQ_COUNT-1:0]                     grant_comb;
    logic [REQ_COUNT-1:0]                     req_ready;
    logic [REQ_COUNT-1:0]                     accept;

    // A killed entry is never a candidate, which is how kill beats grant.
    always_comb begin
        cand = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                cand[b][i] = pend_valid_q[i] & ~kill_by_req[i]
                           & (pend_pr_q[i][LOG_BANK-1:0] == LOG_BANK'(b));
            end
        end
    end

    for (genvar gb = 0; gb < BANK_COUNT; gb++) begin : g_bank
        prf_rr_pick #(
            .N (REQ_COUNT),
            .W (LOG_REQ)
        ) u_pick (
            .cand_vld (cand[gb]),
            .rr_ptr   (rr_ptr_q[gb]),
            .gnt_vld  (gnt_vld[gb]),
            .gnt_idx  (gnt_idx[gb])
        );
    end

    // Fold per-bank picks back into a per-requester grant vector.
    always_comb begin
        grant_comb = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (gnt_vld[b] && gnt_idx[b] == LOG_REQ'(i)) begin
                    grant_comb[i] = 1'b1;
                end
            end
        end
    end

`ifdef PRF_ARB_BYPASS_READY_EN
    // The slot frees at the same edge it is granted, so reload it at that edge.
    assign req_ready = ~pend_valid_q | (grant_comb & ~kill_by_req);
`else
    assign req_ready = ~pend_valid_q;
`endif

    assign accept = req_valid_by_req & req_ready;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_pr_d     = pend_pr_q;
        rr_ptr_d      = rr_ptr_q;
        rd_valid_d    = gnt_vld;
        rd_upper_pr_d = rd_upper_pr_q;
        rd_req_id_d   = rd_req_id_q;
        rd_grant_d    = grant_comb;

        // Clear first, then load: a new request accepted alongside a kill
        // or grant replaces the old entry instead of being dropped.
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (kill_by_req[i] || grant_comb[i]) begin
                pend_valid_d[i] = 1'b0;
            end
            if (accept[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_pr_d[i]    = req_PR_by_req[i];
            end
        end

        // Idle banks keep their pointer and last PR/id.
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (gnt_vld[b]) begin
                rd_upper_pr_d[b] = pend_pr_q[gnt_idx[b]][PR_W-1:LOG_BANK];
                rd_req_id_d[b]   = gnt_idx[b];
                if (gnt_idx[b] == LOG_REQ'(REQ_COUNT - 1)) begin
                    rr_ptr_d[b] = '0;
                end else begin
                    rr_ptr_d[b] = gnt_idx[b] + LOG_REQ'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_valid_q  <= '0;
            pend_pr_q     <= '0;
            rr_ptr_q      <= '0;
            rd_valid_q    <= '0;
            rd_upper_pr_q <= '0;
            rd_req_id_q   <= '0;
            rd_grant_q    <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_pr_q     <= pend_pr_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_valid_q    <= rd_valid_d;
            rd_upper_pr_q <= rd_upper_pr_d;
            rd_req_id_q   <= rd_req_id_d;
            rd_grant_q    <= rd_grant_d;
        end
    end

    assign req_ready_by_req    = req_ready;
    assign rd_valid_by_bank    = rd_valid_q;
    assign rd_upper_PR_by_bank = rd_upper_pr_q;
    assign rd_req_id_by_bank   = rd_req_id_q;
    assign rd_grant_by_req     = rd_grant_q;

endmodule

// File: tb/tb_prf_read_req_arbiter.sv
// Purpose: directed self-checking bench for prf_read_req_arbiter.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: requester holds req_valid until ready where a retry is exercised.
module tb_prf_read_req_arbiter;

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0]      req_valid;
    logic [3:0][6:0] req_pr;
    logic [3:0]      req_ready;
    logic [3:0]      kill;
    logic [3:0]      rd_valid;
    logic [3:0][4:0] rd_upper;
    logic [3:0][1:0] rd_req_id;
    logic [3:0]      rd_grant;

    int total = 0;
    int bad   = 0;

    prf_read_req_arbiter dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .req_valid_by_req    (req_valid),
        .req_PR_by_req       (req_pr),
        .req_ready_by_req    (req_ready),
        .kill_by_req         (kill),
        .rd_valid_by_bank    (rd_valid),
        .rd_upper_PR_by_bank (rd_upper),
        .rd_req_id_by_bank   (rd_req_id),
        .rd_grant_by_req     (rd_grant)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held 2 cycles with all requesters asserting valid
        RST       = 1'b1;
        req_valid = 4'b1111;
        kill      = 4'b0000;
        req_pr    = '0;
        tick();
        chk("rst_rd_valid_in_reset", 32'(rd_valid), 32'h0);
        tick();
        RST       = 1'b0;
        req_valid = 4'b0000;
        chk("rst_ready", 32'(req_ready), 32'hF);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_grant", 32'(rd_grant), 32'h0);
        tick();
        chk("rst_no_accept", 32'(rd_valid), 32'h0);

        // Parallel grants on distinct banks
        req_pr[0] = 7'd8;
        req_pr[1] = 7'd5;
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0000;
        chk("par_ready_busy", 32'(req_ready), 32'hC);
        chk("par_not_yet", 32'(rd_valid), 32'h0);
        tick();
        chk("par_rd_valid", 32'(rd_valid), 32'h3);
        chk("par_upper0", 32'(rd_upper[0]), 32'd2);
        chk("par_upper1", 32'(rd_upper[1]), 32'd1);
        chk("par_id0", 32'(rd_req_id[0]), 32'd0);
        chk("par_id1", 32'(rd_req_id[1]), 32'd1);
        chk("par_grant", 32'(rd_grant), 32'h3);
        tick();
        chk("par_pulse_end", 32'(rd_valid), 32'h0);
        chk("par_ready_back", 32'(req_ready), 32'hF);

        // Four-way conflict on bank 2, round-robin from 0
        req_pr[0] = 7'd2;
        req_pr[1] = 7'd6;
        req_pr[2] = 7'd10;
        req_pr[3] = 7'd14;
        req_valid = 4'b1111;
        tick();
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_valid_%0d", k), 32'(rd_valid), 32'h4);
            chk($sformatf("rr_id_%0d", k), 32'(rd_req_id[2]), 32'(k));
            chk($sformatf("rr_upper_%0d", k), 32'(rd_upper[2]), 32'(k));
            chk($sformatf("rr_grant_%0d", k), 32'(rd_grant), 32'(1 << k));
        end
        chk("rr_ptr2_wrap", 32'(dut.rr_ptr_q[2]), 32'd0);
        tick();
        chk("rr_idle", 32'(rd_valid), 32'h0);

        // Kill on the grant cycle
        req_pr[1] = 7'd3;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        kill      = 4'b0010;
        chk("kill_ready_busy", 32'(req_ready), 32'hD);
        tick();
        kill      = 4'b0000;
        chk("kill_rd_valid", 32'(rd_valid), 32'h0);
        chk("kill_rd_grant", 32'(rd_grant), 32'h0);
        chk("kill_ready", 32'(req_ready), 32'hF);
        chk("kill_rr_ptr3", 32'(dut.rr_ptr_q[3]), 32'd0);
        tick();
        chk("kill_no_late_read", 32'(rd_valid), 32'h0);

        // Back-to-back requests from requester 2 on bank 1
        req_pr[2] = 7'd1;
        req_valid = 4'b0100;
        tick();
        req_pr[2] = 7'd9;
`ifdef PRF_ARB_BYPASS_READY_EN
        chk("byp_ready_on_grant", 32'(req_ready[2]), 32'd1);
        tick();
        req_valid = 4'b0000;
        chk("byp_first_valid", 32'(rd_valid), 32'h2);
        chk("byp_first_upper", 32'(rd_upper[1]), 32'd0);
        chk("byp_first_id", 32'(rd_req_id[1]), 32'd2);
        tick();
        chk("byp_second_valid", 32'(rd_valid), 32'h2);
        chk("byp_second_upper", 32'(rd_upper[1]), 32'd2);
        chk("byp_second_id", 32'(rd_req_id[1]), 32'd2);
`else
        chk("nobyp_ready_busy", 32'(req_ready[2]), 32'd0);
        tick();
        chk("nobyp_first_valid", 32'(rd_valid), 32'h2);
        chk("nobyp_first_upper", 32'(rd_upper[1]), 32'd0);
        chk("nobyp_first_id", 32'(rd_req_id[1]), 32'd2);
        chk("nobyp_ready_free", 32'(req_ready[2]), 32'd1);
        tick();
        req_valid = 4'b0000;
        chk("nobyp_gap", 32'(rd_valid), 32'h0);
        tick();
        chk("nobyp_second_valid", 32'(rd_valid), 32'h2);
        chk("nobyp_second_upper", 32'(rd_upper[1]), 32'd2);
        chk("nobyp_second_id", 32'(rd_req_id[1]), 32'd2);
`endif
        tick();

        // Reset while three requests are pending
        req_pr[0] = 7'd0;
        req_pr[1] = 7'd4;
        req_pr[3] = 7'd12;
        req_valid = 4'b1011;
        tick();
        req_valid = 4'b0000;
        RST       = 1'b1;
        tick();
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("mid_rst_rd_grant", 32'(rd_grant), 32'h0);
        chk("mid_rst_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
        RST       = 1'b0;
        chk("mid_rst_ready", 32'(req_ready), 32'hF);
        tick();
        chk("mid_rst_no_read", 32'(rd_valid), 32'h0);

        // Round-robin on bank 0 restarts from requester 0 after reset
        req_pr[0] = 7'd0;
        req_pr[1] = 7'd4;
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0000;
        tick();
        chk("post_rst_first_id", 32'(rd_req_id[0]), 32'd0);
        chk("post_rst_first_valid", 32'(rd_valid), 32'h1);
        tick();
        chk("post_rst_second_id", 32'(rd_req_id[0]), 32'd1);
        chk("post_rst_second_valid", 32'(rd_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
